acc_file: RTL and testbench
===========================

Name: acc_file

Overview:
- Accumulator register file directly downstream of the ALU 1-bit shifter.
- Holds the two 56-bit accumulators A and B (ext[55:48] : msb[47:24] : lsb[23:0]) and captures the shifter result on ALU write-back.
- Feeds full-width operands back to the ALU input mux.
- Drives limited (saturated) 24-bit values onto the data bus and maintains the ALU condition-code bits, including a sticky limit flag.

Parameters:
- AW, 56, accumulator width (ext 8 + msb 24 + lsb 24)
- DW, 24, data-bus word width
- LIM_POS, 24'h7FFFFF, bus value on positive limit
- LIM_NEG, 24'h800000, bus value on negative limit

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- alu_we  in  1  write ALU/shifter result into selected accumulator
- alu_sel  in  1  ALU destination: 0=A, 1=B
- alu_data  in  56  result from shifter output
- alu_v  in  1  overflow indication accompanying alu_data
- mv_we  in  1  bus move into accumulator
- mv_sel  in  1  move destination: 0=A, 1=B
- mv_data  in  24  bus word for move
- op_sel  in  1  ALU operand read select: 0=A, 1=B
- op_data  out  56  unlimited accumulator value to ALU
- bus_re  in  1  bus read strobe
- bus_sel  in  1  bus read select: 0=A, 1=B
- bus_data  out  24  limited msb word
- bus_lim  out  1  current bus read is being limited (combinational)
- l_clr  in  1  clear sticky L flag
- ccr_n, ccr_z, ccr_v, ccr_e, ccr_u  out  1 each  condition codes from last ALU write
- ccr_l  out  1  sticky limit flag

Behaviour:
- Reset (async, reset_n=0):
  - A=B=0.
  - ccr_n=0, ccr_z=1, ccr_v=0, ccr_e=0, ccr_u=1, ccr_l=0.
  - op_data=0, bus_data=0, bus_lim=0, since outputs follow the cleared registers.
  - Reset asserted mid-write discards the write. The first edge after release behaves normally.
- ALU write: on the clk edge with alu_we=1, the selected accumulator <= alu_data. One-cycle latency; the new value is visible on op_data/bus_data the following cycle.
- Move write: on the clk edge with mv_we=1, the selected accumulator <= {8{mv_data[23]}, mv_data, 24'h0} (sign-extend ext, clear lsb). Condition codes are unchanged.
- Simultaneous writes, same accumulator: alu_we wins and the move is dropped. Different accumulators: both writes occur.
- Reads are combinational from registers:
  - op_data = selected accumulator.
  - A read in the same cycle as a write to that accumulator returns the old value; there is no bypass.
- Limiter (bus path), with acc = bus_sel accumulator:
  - E condition: acc[55:47] not all equal.
  - If E: bus_lim=1, and bus_data=LIM_POS when acc[55]=0, LIM_NEG when acc[55]=1.
  - Else: bus_lim=0, bus_data=acc[47:24].
  - bus_lim is valid regardless of bus_re.
- Condition codes update only on edges with alu_we=1, computed from alu_data:
  - N=alu_data[55].
  - Z=(alu_data==0).
  - V=alu_v.
  - E=alu_data[55:47] not all equal.
  - U=~(alu_data[47]^alu_data[46]).
- Sticky L:
  - Set on an edge where bus_re=1 and bus_lim=1.
  - Cleared on an edge where l_clr=1.
  - If set and clear occur on the same edge, set wins.
  - L holds otherwise, including across ALU writes.
- Width rules: there is no arithmetic in this block. All values pass through bit-exact except the limiter substitution.

Test Plan:
- Reset with bus_re=1 -> bus_data=0, bus_lim=0, ccr_z=1, ccr_u=1, ccr_l=0; after release the registers hold until written.
- alu_we=1, alu_sel=0, alu_data=56'h00_400000_000001, alu_v=0 -> next cycle op_data(op_sel=0)=56'h00_400000_000001, N=0, Z=0, E=0, U=0; bus read A gives 24'h400000, bus_lim=0.
- Write B=56'h01_000000_000000, then bus_re=1, bus_sel=1 -> bus_data=24'h7FFFFF, bus_lim=1, ccr_e=1; ccr_l=1 after the edge and stays 1 over 3 idle cycles.
- Write A=56'hFE_000000_000000, bus_re=1, bus_sel=0 with l_clr=1 on the same edge -> bus_data=24'h800000, ccr_l remains 1 (set wins); l_clr alone on the next edge -> ccr_l=0.
- mv_we=1, mv_sel=1, mv_data=24'h900000 -> B=56'hFF_900000_000000, ccr bits unchanged; same-edge alu_we to B with alu_data=0 -> B=0, Z=1, move dropped.
- alu_we to A plus op_sel=0 in the same cycle -> op_data shows the old A that cycle and the new A next cycle; alu_v=1 -> ccr_v=1 after the edge.

Source files
------------

// File: rtl/acc_file_if.sv
// acc_file_if: ALU write-back, bus move, operand/bus read and condition-code signals of the accumulator file
interface acc_file_if #(
  parameter int AW = 56,
  parameter int DW = 24
);
  logic          alu_we;
  logic          alu_sel;
  logic [AW-1:0] alu_data;
  logic          alu_v;
  logic          mv_we;
  logic          mv_sel;
  logic [DW-1:0] mv_data;
  logic          op_sel;
  logic [AW-1:0] op_data;
  logic          bus_re;
  logic          bus_sel;
  logic [DW-1:0] bus_data;
  logic          bus_lim;
  logic          l_clr;
  logic          ccr_n;
  logic          ccr_z;
  logic          ccr_v;
  logic          ccr_e;
  logic          ccr_u;
  logic          ccr_l;
  modport master (
    output alu_we, alu_sel, alu_data, alu_v, mv_we, mv_sel, mv_data, op_sel, bus_re, bus_sel, l_clr,
    input  op_data, bus_data, bus_lim, ccr_n, ccr_z, ccr_v, ccr_e, ccr_u, ccr_l
  );
  modport slave (
    input  alu_we, alu_sel, alu_data, alu_v, mv_we, mv_sel, mv_data, op_sel, bus_re, bus_sel, l_clr,
    output op_data, bus_data, bus_lim, ccr_n, ccr_z, ccr_v, ccr_e, ccr_u, ccr_l
  );
endinterface

// File: rtl/acc_file.sv
// acc_file: A/B accumulators with ALU write-back, bus moves, saturating bus reads and condition codes
module acc_file #(
  parameter int             AW      = 56,
  parameter int             DW      = 24,
  parameter logic [DW-1:0]  LIM_POS = 24'h7FFFFF,
  parameter logic [DW-1:0]  LIM_NEG = 24'h800000
) (
  input logic       clk,
  input logic       reset_n,
  acc_file_if.slave io
);
  logic [AW-1:0] a, b, a_nx, b_nx, mv_ext, rd;
  logic          e_rd, n, z, v, e, u, l;
  assign mv_ext = {{(AW-2*DW){io.mv_data[DW-1]}}, io.mv_data, {DW{1'b0}}};
  // next accumulator values (ALU beats a move to the same target) and the combinational read paths
  always_comb begin
    a_nx = (io.alu_we && !io.alu_sel) ? io.alu_data : (io.mv_we && !io.mv_sel) ? mv_ext : a;
    b_nx = (io.alu_we &&  io.alu_sel) ? io.alu_data : (io.mv_we &&  io.mv_sel) ? mv_ext : b;
    rd   = io.bus_sel ? b : a;
    e_rd = !((&rd[AW-1:2*DW-1]) || !(|rd[AW-1:2*DW-1]));
    io.op_data  = io.op_sel ? b : a;
    io.bus_lim  = e_rd;
    io.bus_data = e_rd ? (rd[AW-1] ? LIM_NEG : LIM_POS) : rd[2*DW-1:DW];
  end
  // accumulator registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a <= '0;
      b <= '0;
    end else begin
      a <= a_nx;
      b <= b_nx;
    end
  end
  // condition codes follow the ALU result only; a bus move leaves them alone
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n <= 1'b0;
      z <= 1'b1;
      v <= 1'b0;
      e <= 1'b0;
      u <= 1'b1;
    end else if (io.alu_we) begin
      n <= io.alu_data[AW-1];
      z <= io.alu_data == '0;
      v <= io.alu_v;
      e <= !((&io.alu_data[AW-1:2*DW-1]) || !(|io.alu_data[AW-1:2*DW-1]));
      u <= !(io.alu_data[2*DW-1] ^ io.alu_data[2*DW-2]);
    end
  end
  // sticky limit flag: a limited bus read takes priority over a clear on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) l <= 1'b0;
    else if (io.bus_re && e_rd) l <= 1'b1;
    else if (io.l_clr) l <= 1'b0;
  end
  assign io.ccr_n = n;
  assign io.ccr_z = z;
  assign io.ccr_v = v;
  assign io.ccr_e = e;
  assign io.ccr_u = u;
  assign io.ccr_l = l;
endmodule

// File: tb/tb_acc_file.sv
// tb_acc_file: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_acc_file;
  logic clk, reset_n;
  acc_file_if io ();
  acc_file dut (.clk(clk), .reset_n(reset_n), .io(io));
  typedef struct {
    string       nm;
    logic [55:0] op;
    logic [23:0] bus;
    logic        lim;
    logic [5:0]  cc;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  int pass_cnt = 0;
  int total_cnt = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic cmp(string nm, string f, logic [55:0] act, logic [55:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s.%s: got %h expected %h", nm, f, act, exp);
  endtask
  // monitor: every negedge with a pending expectation compares the DUT outputs
  always @(negedge clk) begin
    if (q.size() != 0) begin
      cur = q.pop_front();
      cmp(cur.nm, "op_data", io.op_data, cur.op);
      cmp(cur.nm, "bus_data", {32'h0, io.bus_data}, {32'h0, cur.bus});
      cmp(cur.nm, "bus_lim", {55'h0, io.bus_lim}, {55'h0, cur.lim});
      cmp(cur.nm, "ccr", {50'h0, io.ccr_n, io.ccr_z, io.ccr_v, io.ccr_e, io.ccr_u, io.ccr_l}, {50'h0, cur.cc});
    end
  end
  task automatic idle();
    io.alu_we = 0; io.alu_sel = 0; io.alu_data = '0; io.alu_v = 0;
    io.mv_we = 0; io.mv_sel = 0; io.mv_data = '0;
    io.op_sel = 0; io.bus_re = 0; io.bus_sel = 0; io.l_clr = 0;
  endtask
  task automatic chk(string nm, logic [55:0] op, logic [23:0] bus, logic lim, logic [5:0] cc);
    exp_t x;
    x.nm = nm; x.op = op; x.bus = bus; x.lim = lim; x.cc = cc;
    q.push_back(x);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask
  // cc = {n, z, v, e, u, l}
  initial begin
    idle();
    reset_n = 0;
    io.bus_re = 1;
    io.alu_we = 1; io.alu_data = 56'h01_234567_89ABCD;
    chk("rst", 56'h0, 24'h0, 0, 6'b010010);
    reset_n = 1;
    idle();
    chk("hold", 56'h0, 24'h0, 0, 6'b010010);
    io.alu_we = 1; io.alu_data = 56'h00_400000_000001;
    chk("wr_a_old", 56'h0, 24'h0, 0, 6'b010010);
    idle(); io.bus_re = 1;
    chk("rd_a", 56'h00_400000_000001, 24'h400000, 0, 6'b000000);
    idle(); io.alu_we = 1; io.alu_sel = 1; io.alu_data = 56'h01_000000_000000;
    chk("wr_b", 56'h00_400000_000001, 24'h400000, 0, 6'b000000);
    idle(); io.bus_re = 1; io.bus_sel = 1; io.op_sel = 1;
    chk("lim_pos", 56'h01_000000_000000, 24'h7FFFFF, 1, 6'b000110);
    idle(); io.bus_sel = 1; io.op_sel = 1;
    for (int i = 0; i < 3; i++) chk("l_hold", 56'h01_000000_000000, 24'h7FFFFF, 1, 6'b000111);
    idle(); io.alu_we = 1; io.alu_data = 56'hFE_000000_000000;
    chk("wr_a2", 56'h00_400000_000001, 24'h400000, 0, 6'b000111);
    idle(); io.bus_re = 1; io.l_clr = 1;
    chk("lim_neg", 56'hFE_000000_000000, 24'h800000, 1, 6'b100111);
    idle(); io.l_clr = 1;
    chk("set_wins", 56'hFE_000000_000000, 24'h800000, 1, 6'b100111);
    idle(); io.mv_we = 1; io.mv_sel = 1; io.mv_data = 24'h900000; io.op_sel = 1; io.bus_sel = 1;
    chk("clr_l", 56'h01_000000_000000, 24'h7FFFFF, 1, 6'b100110);
    idle(); io.alu_we = 1; io.alu_sel = 1; io.mv_we = 1; io.mv_sel = 1; io.mv_data = 24'h123456;
    io.op_sel = 1; io.bus_sel = 1;
    chk("mv_b", 56'hFF_900000_000000, 24'h900000, 0, 6'b100110);
    idle(); io.alu_we = 1; io.alu_data = 56'h00_123456_ABCDEF; io.alu_v = 1;
    io.mv_we = 1; io.mv_sel = 1; io.mv_data = 24'h7FFFFF; io.bus_sel = 1;
    chk("alu_wins", 56'hFE_000000_000000, 24'h000000, 0, 6'b010010);
    idle(); io.bus_sel = 1;
    chk("dual", 56'h00_123456_ABCDEF, 24'h7FFFFF, 0, 6'b001010);
    idle(); io.op_sel = 1;
    chk("dual_a", 56'h00_7FFFFF_000000, 24'h123456, 0, 6'b001010);
    idle(); io.alu_we = 1; io.alu_data = 56'h00_111111_000000;
    #1 reset_n = 0;
    chk("rst_mid", 56'h0, 24'h0, 0, 6'b010010);
    reset_n = 1;
    idle();
    chk("post_rst", 56'h0, 24'h0, 0, 6'b010010);
    io.alu_we = 1; io.alu_sel = 1; io.alu_data = 56'hFF_800000_000000; io.op_sel = 1; io.bus_sel = 1;
    chk("first_wr", 56'h0, 24'h0, 0, 6'b010010);
    idle(); io.op_sel = 1; io.bus_sel = 1;
    chk("first_edge", 56'hFF_800000_000000, 24'h800000, 0, 6'b100000);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
